uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_pkg.sv | 12 +
 rtl/uart_tx_scheduler_if.sv | 25 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 102 ++++++++++
 tb/tb_uart_tx_scheduler.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART word scheduler.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [3:0] HEADER_MARK = 4'hA;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and uart_tx handshake bundle for the scheduler.
interface uart_tx_scheduler_if #(
  parameter int N_REQ   = 4,
  parameter int NB_WORD = 32,
  parameter int NB_DATA = 8
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*NB_WORD-1:0] req_data;
  logic [N_REQ-1:0]         req_ready;
  logic                     tx_start;
  logic [NB_DATA-1:0]       tx_din;
  logic                     tx_done_tick;
  logic                     busy;
  logic [2:0]               grant_id;

  modport master (
    output req_valid, req_data, tx_done_tick,
    input  req_ready, tx_start, tx_din, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data, tx_done_tick,
    output req_ready, tx_start, tx_din, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first requester at or after last_grant+1, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       gnt_idx
);

  int               i;
  logic [N_REQ-1:0] sh;

  // Scan farthest offset first so the nearest valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = 3'd0;
    i       = 0;
    sh      = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      i  = (int'(last_grant) + off) % N_REQ;
      sh = req >> i;
      if (sh[0]) begin
        gnt     = N_REQ'(1) << i;
        gnt_idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Serialises requester words into header + MSB-first bytes for an external uart_tx.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int NB_WORD   = 32,
  parameter int NB_DATA   = 8,
  parameter int HEADER_EN = 1
) (
  input logic            clk,
  input logic            reset,
  uart_tx_scheduler_if.slave bus
);

  localparam int NB_BYTES = NB_WORD / NB_DATA + HEADER_EN;
  localparam int CW       = $clog2(NB_BYTES + 1);

  state_t                   state;
  logic [NB_WORD-1:0]       word_q;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            cnt_nxt;
  logic [2:0]               last_grant;
  logic [N_REQ-1:0]         gnt;
  logic [2:0]               gnt_idx;
  logic [N_REQ*NB_WORD-1:0] data_sh;
  logic [NB_WORD-1:0]       word_sel;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign data_sh  = bus.req_data >> (int'(gnt_idx) * NB_WORD);
  assign word_sel = data_sh[NB_WORD-1:0];
  assign cnt_nxt  = cnt + 1'b1;

  // Byte k of the frame: header first (if enabled), then word bytes MSB first.
  function automatic logic [NB_DATA-1:0] pick(input logic [NB_WORD-1:0] w,
                                              input logic [2:0]         id,
                                              input logic [CW-1:0]      k);
    int                 j;
    logic [NB_WORD-1:0] sh;
    j  = int'(k) - HEADER_EN;
    sh = '0;
    if (j < 0) begin
      pick = NB_DATA'({HEADER_MARK, 1'b0, id});
    end else begin
      sh   = w << (j * NB_DATA);
      pick = sh[NB_WORD-1 -: NB_DATA];
    end
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      word_q        <= '0;
      cnt           <= '0;
      last_grant    <= 3'(N_REQ - 1);
      bus.tx_start  <= 1'b0;
      bus.tx_din    <= '0;
      bus.req_ready <= '0;
      bus.busy      <= 1'b0;
      bus.grant_id  <= 3'd0;
    end else begin
      bus.tx_start  <= 1'b0;
      bus.req_ready <= '0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            bus.req_ready <= gnt;
            word_q        <= word_sel;
            bus.grant_id  <= gnt_idx;
            last_grant    <= gnt_idx;
            cnt           <= '0;
            bus.tx_din    <= pick(word_sel, gnt_idx, '0);
            bus.tx_start  <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (bus.tx_done_tick) begin
            cnt <= cnt_nxt;
            if (int'(cnt_nxt) < NB_BYTES) begin
              bus.tx_din   <= pick(word_q, bus.grant_id, cnt_nxt);
              bus.tx_start <= 1'b1;
              state        <= SEND;
            end else begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed + randomized bench for uart_tx_scheduler (HEADER_EN=1 and HEADER_EN=0 copies).
module tb_uart_tx_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.N_REQ(4), .NB_WORD(32), .NB_DATA(8)) b0 ();
  uart_tx_scheduler_if #(.N_REQ(4), .NB_WORD(32), .NB_DATA(8)) b1 ();

  uart_tx_scheduler #(.N_REQ(4), .NB_WORD(32), .NB_DATA(8), .HEADER_EN(1)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  uart_tx_scheduler #(.N_REQ(4), .NB_WORD(32), .NB_DATA(8), .HEADER_EN(0)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));

  logic [3:0]   req_valid = 4'b0;
  logic [31:0]  word_arr [4];
  logic         done = 1'b0;
  logic [127:0] req_data;
  bit           sel = 1'b0;
  int           last_exp = 3;
  int           vectors = 0;
  int           miscompares = 0;

  assign req_data        = {word_arr[3], word_arr[2], word_arr[1], word_arr[0]};
  assign b0.req_valid    = req_valid;
  assign b0.req_data     = req_data;
  assign b0.tx_done_tick = done;
  assign b1.req_valid    = req_valid;
  assign b1.req_data     = req_data;
  assign b1.tx_done_tick = done;

  logic       o_tx_start, o_busy;
  logic [7:0] o_tx_din;
  logic [3:0] o_req_ready;
  logic [2:0] o_grant_id;
  assign o_tx_start  = sel ? b1.tx_start  : b0.tx_start;
  assign o_busy      = sel ? b1.busy      : b0.busy;
  assign o_tx_din    = sel ? b1.tx_din    : b0.tx_din;
  assign o_req_ready = sel ? b1.req_ready : b0.req_ready;
  assign o_grant_id  = sel ? b1.grant_id  : b0.grant_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut(input bit s);
    @(negedge clk);
    reset = 1'b0; req_valid = 4'b0; done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sel = s; reset = 1'b1; last_exp = 3;
  endtask

  // Reference: round-robin winner from last_exp, header then bytes MSB first.
  task automatic run_word(input bit refill, input bit spur, input bit mod_data, input int limit);
    int id, n, nl, hdr, waitc, hold, c;
    logic [31:0] w;
    logic [7:0]  eb;
    hdr = sel ? 0 : 1;
    id  = 0;
    for (int off = 4; off >= 1; off--) begin
      c = (last_exp + off) % 4;
      if (req_valid[2'(c)]) id = c;
    end
    w  = word_arr[id];
    n  = 4 + hdr;
    nl = (limit < n) ? limit : n;
    for (int k = 0; k < nl; k++) begin
      waitc = 0;
      while (o_tx_start !== 1'b1 && waitc < 20) begin
        @(negedge clk); waitc++;
      end
      check("tx_start", o_tx_start, 1);
      check("start_latency", waitc, (k == 0) ? 1 : 0);
      if (k == 0) begin
        check("req_ready", o_req_ready, 32'd1 << id);
        check("grant_id", o_grant_id, id);
        last_exp = id;
        if (refill) word_arr[id] = $urandom;
        else        req_valid[2'(id)] = 1'b0;
      end
      check("busy", o_busy, 1);
      eb = (hdr == 1 && k == 0) ? {4'hA, 1'b0, 3'(id)} : 8'(w >> (8 * (3 - (k - hdr))));
      check("tx_din", o_tx_din, eb);
      if (spur && k == 1) done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("start_one_cycle", o_tx_start, 0);
      check("din_stable", o_tx_din, eb);
      if (mod_data) for (int i = 0; i < 4; i++) word_arr[i] = $urandom;
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        @(negedge clk);
        check("din_hold", o_tx_din, eb);
        check("ready_quiet", o_req_ready, 0);
      end
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end
    if (nl == n) begin
      check("busy_drop", o_busy, 0);
      check("idle_no_start", o_tx_start, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) word_arr[i] = 32'h0;
    #1;
    check("rst_tx_start", o_tx_start, 0);
    check("rst_tx_din", o_tx_din, 0);
    check("rst_req_ready", o_req_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_grant_id", o_grant_id, 0);
    @(negedge clk);
    reset = 1'b1;

    // single requester, fixed word
    word_arr[0] = 32'hFF00FF00;
    req_valid   = 4'b0001;
    run_word(0, 0, 0, 99);

    // all requesters valid: rotation from 0
    reset_dut(0);
    for (int i = 0; i < 4; i++) word_arr[i] = $urandom;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) run_word(1, 0, 0, 99);

    // random patterns, spurious done ticks, data churn in flight
    reset_dut(0);
    for (int it = 0; it < 8; it++) begin
      req_valid = 4'b0;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("idle_spur_busy", o_busy, 0);
      check("idle_spur_start", o_tx_start, 0);
      for (int i = 0; i < 4; i++) word_arr[i] = $urandom;
      req_valid = 4'($urandom_range(1, 15));
      run_word(0, 1, it[0], 99);
    end

    // reset mid-word
    reset_dut(0);
    word_arr[2] = $urandom;
    req_valid   = 4'b0100;
    run_word(0, 0, 0, 2);
    reset = 1'b0;
    #1;
    check("abort_tx_start", o_tx_start, 0);
    check("abort_busy", o_busy, 0);
    check("abort_req_ready", o_req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; last_exp = 3;
    word_arr[0] = $urandom; word_arr[1] = $urandom;
    req_valid = 4'b0011;
    run_word(0, 0, 0, 99);
    run_word(0, 0, 0, 99);
    repeat (6) begin
      @(negedge clk);
      check("no_resend", o_tx_start, 0);
    end

    // no header
    reset_dut(1);
    word_arr[0] = 32'hF0F0FF18;
    req_valid   = 4'b0001;
    run_word(0, 0, 0, 99);
    repeat (4) begin
      @(negedge clk);
      check("nohdr_extra_start", o_tx_start, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
